tlp_agent_arbiter: RTL and testbench

Round-robin arbiter that shares the single TLP transmit port of `pcie_tx_axi` between up to `NB_AGENTS` TLP-producing masters (`dmawr2tlp` instances, register-read completers, interrupt generators). It serializes whole TLPs: one agent owns the downstream port from request to last data beat. Header and sideband fields of the owner are multiplexed through, and data handshakes are routed only to the owner. It sits between the agents' `tlp_*` ports and `pcie_tx_axi`, which is instantiated with `NB_PCIE_AGENTS=1`.

---
 rtl/tlp_agent_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_tlp_agent_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_agent_arbiter.sv
// Round-robin arbiter that serializes whole TLPs from several agents onto the
// single pcie_tx_axi transmit port; the owner keeps the port until its last beat.
module tlp_agent_arbiter #(
    parameter int NB_AGENTS  = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                            sys_clk,
    input  logic                            sys_reset,
    input  logic                            cfg_bus_mast_en,
    input  logic [NB_AGENTS-1:0]            s_req_to_send,
    output logic [NB_AGENTS-1:0]            s_grant,
    input  logic [7*NB_AGENTS-1:0]          s_fmt_type,
    input  logic [10*NB_AGENTS-1:0]         s_length_in_dw,
    input  logic [NB_AGENTS-1:0]            s_src_rdy_n,
    output logic [NB_AGENTS-1:0]            s_dst_rdy_n,
    input  logic [DATA_WIDTH*NB_AGENTS-1:0] s_data,
    input  logic [64*NB_AGENTS-1:0]         s_address,
    input  logic [8*NB_AGENTS-1:0]          s_ldwbe_fdwbe,
    input  logic [2*NB_AGENTS-1:0]          s_attr,
    input  logic [24*NB_AGENTS-1:0]         s_transaction_id,
    input  logic [13*NB_AGENTS-1:0]         s_byte_count,
    input  logic [7*NB_AGENTS-1:0]          s_lower_address,
    output logic                            m_req_to_send,
    input  logic                            m_grant,
    output logic [6:0]                      m_fmt_type,
    output logic [9:0]                      m_length_in_dw,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [63:0]                     m_address,
    output logic [7:0]                      m_ldwbe_fdwbe,
    output logic [1:0]                      m_attr,
    output logic [23:0]                     m_transaction_id,
    output logic [12:0]                     m_byte_count,
    output logic [6:0]                      m_lower_address,
    output logic                            m_src_rdy_n,
    input  logic                            m_dst_rdy_n
);

    localparam int OW = (NB_AGENTS > 1) ? $clog2(NB_AGENTS) : 1;
    localparam logic [OW-1:0] LAST_RST = OW'(NB_AGENTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Number of 2-DW beats in a TLP; a zero length field encodes 1024 DW.
    function automatic logic [10:0] beats_for_len(input logic [9:0] len);
        logic [10:0] dw;
        dw = (len == 10'd0) ? 11'd1024 : {1'b0, len};
        return (dw + 11'd1) >> 1'b1;
    endfunction

    state_e                state_q, state_d;
    logic [OW-1:0]         owner_q, owner_d;
    logic [OW-1:0]         last_owner_q, last_owner_d;
    logic [10:0]           beats_q, beats_d;
    logic [NB_AGENTS-1:0]  grant_q, grant_d;
    logic                  req_q, req_d;

    logic                  win_found_s;
    logic [OW-1:0]         win_idx_s;
    logic                  xfer_s;
    logic                  beat_s;

    logic [6:0]            fmt_a  [NB_AGENTS];
    logic [9:0]            len_a  [NB_AGENTS];
    logic [DATA_WIDTH-1:0] data_a [NB_AGENTS];
    logic [63:0]           addr_a [NB_AGENTS];
    logic [7:0]            be_a   [NB_AGENTS];
    logic [1:0]            attr_a [NB_AGENTS];
    logic [23:0]           tid_a  [NB_AGENTS];
    logic [12:0]           bc_a   [NB_AGENTS];
    logic [6:0]            la_a   [NB_AGENTS];

    for (genvar g = 0; g < NB_AGENTS; g++) begin : g_slice
        assign fmt_a[g]  = s_fmt_type[g*7 +: 7];
        assign len_a[g]  = s_length_in_dw[g*10 +: 10];
        assign data_a[g] = s_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign addr_a[g] = s_address[g*64 +: 64];
        assign be_a[g]   = s_ldwbe_fdwbe[g*8 +: 8];
        assign attr_a[g] = s_attr[g*2 +: 2];
        assign tid_a[g]  = s_transaction_id[g*24 +: 24];
        assign bc_a[g]   = s_byte_count[g*13 +: 13];
        assign la_a[g]   = s_lower_address[g*7 +: 7];
    end

    // Header fields are not re-registered: the mux simply follows the latched owner.
    assign m_fmt_type       = fmt_a[owner_q];
    assign m_length_in_dw   = len_a[owner_q];
    assign m_data           = data_a[owner_q];
    assign m_address        = addr_a[owner_q];
    assign m_ldwbe_fdwbe    = be_a[owner_q];
    assign m_attr           = attr_a[owner_q];
    assign m_transaction_id = tid_a[owner_q];
    assign m_byte_count     = bc_a[owner_q];
    assign m_lower_address  = la_a[owner_q];

    assign s_grant       = grant_q;
    assign m_req_to_send = req_q;
    assign xfer_s        = (state_q == ST_XFER);
    assign beat_s        = xfer_s && !s_src_rdy_n[owner_q] && !m_dst_rdy_n;
    assign m_src_rdy_n   = xfer_s ? s_src_rdy_n[owner_q] : 1'b1;

    // Route the downstream accept only to the owner while data is moving.
    always_comb begin
        s_dst_rdy_n = '1;
        if (xfer_s) begin
            s_dst_rdy_n[owner_q] = m_dst_rdy_n;
        end else begin
            s_dst_rdy_n = '1;
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        logic [OW:0] sum_v;
        sum_v       = '0;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 1; i <= NB_AGENTS; i++) begin
            sum_v = {1'b0, last_owner_q} + (OW+1)'(i);
            if (sum_v >= (OW+1)'(NB_AGENTS)) begin
                sum_v = sum_v - (OW+1)'(NB_AGENTS);
            end else begin
                sum_v = sum_v;
            end
            if (!win_found_s && s_req_to_send[sum_v[OW-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = sum_v[OW-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic of the ownership FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beats_d      = beats_q;
        grant_d      = grant_q;
        req_d        = req_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_bus_mast_en && win_found_s) begin
                    owner_d = win_idx_s;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (m_grant) begin
                    req_d            = 1'b0;
                    grant_d          = '0;
                    grant_d[owner_q] = 1'b1;
                    beats_d          = beats_for_len(len_a[owner_q]);
                    state_d          = ST_XFER;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_XFER: begin
                if (beat_s) begin
                    beats_d = beats_q - 11'd1;
                    state_d = (beats_q == 11'd1) ? ST_DONE : ST_XFER;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                grant_d      = '0;
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any TLP in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_RST;
            beats_q      <= 11'd0;
            grant_q      <= '0;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beats_q      <= beats_d;
            grant_q      <= grant_d;
            req_q        <= req_d;
        end
    end

endmodule

// File: tb/tb_tlp_agent_arbiter.sv
// Bench for tlp_agent_arbiter: a cycle monitor with a transaction-level model,
// a table of single-TLP length vectors, directed corner sequences and random traffic.
module tb_tlp_agent_arbiter;

    localparam int NB = 3;

    logic            sys_clk = 1'b0;
    logic            sys_reset;
    logic            cfg_bus_mast_en;
    logic [NB-1:0]   s_req_to_send, s_grant, s_src_rdy_n, s_dst_rdy_n;
    logic [7*NB-1:0] s_fmt_type, s_lower_address;
    logic [10*NB-1:0] s_length_in_dw;
    logic [64*NB-1:0] s_data, s_address;
    logic [8*NB-1:0] s_ldwbe_fdwbe;
    logic [2*NB-1:0] s_attr;
    logic [24*NB-1:0] s_transaction_id;
    logic [13*NB-1:0] s_byte_count;
    logic            m_req_to_send, m_grant, m_src_rdy_n, m_dst_rdy_n;
    logic [6:0]      m_fmt_type, m_lower_address;
    logic [9:0]      m_length_in_dw;
    logic [63:0]     m_data, m_address;
    logic [7:0]      m_ldwbe_fdwbe;
    logic [1:0]      m_attr;
    logic [23:0]     m_transaction_id;
    logic [12:0]     m_byte_count;

    always #5 sys_clk = ~sys_clk;

    tlp_agent_arbiter #(.NB_AGENTS(NB), .DATA_WIDTH(64)) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .cfg_bus_mast_en(cfg_bus_mast_en),
        .s_req_to_send(s_req_to_send), .s_grant(s_grant), .s_fmt_type(s_fmt_type),
        .s_length_in_dw(s_length_in_dw), .s_src_rdy_n(s_src_rdy_n), .s_dst_rdy_n(s_dst_rdy_n),
        .s_data(s_data), .s_address(s_address), .s_ldwbe_fdwbe(s_ldwbe_fdwbe),
        .s_attr(s_attr), .s_transaction_id(s_transaction_id), .s_byte_count(s_byte_count),
        .s_lower_address(s_lower_address), .m_req_to_send(m_req_to_send), .m_grant(m_grant),
        .m_fmt_type(m_fmt_type), .m_length_in_dw(m_length_in_dw), .m_data(m_data),
        .m_address(m_address), .m_ldwbe_fdwbe(m_ldwbe_fdwbe), .m_attr(m_attr),
        .m_transaction_id(m_transaction_id), .m_byte_count(m_byte_count),
        .m_lower_address(m_lower_address), .m_src_rdy_n(m_src_rdy_n), .m_dst_rdy_n(m_dst_rdy_n)
    );

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;
    int len_cfg [NB];
    bit keep_req [NB];

    typedef struct { int owner; int beats; int gcyc; int first; int lastb; } tlp_t;
    tlp_t log_q [$];

    // Reference model: who owns the port and how many beats remain, in plain integers.
    bit md_asking = 1'b0, md_moving = 1'b0, md_closing = 1'b0;
    int md_owner = 0, md_mux = 0, md_last = NB - 1, md_left = 0;
    int md_beats = 0, md_gcyc = 0, md_first = -1, md_lastb = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NB-1:0] r);
        for (int k = 1; k <= NB; k++) begin
            if (r[(last + k) % NB]) return (last + k) % NB;
        end
        return -1;
    endfunction

    function automatic int beats_of(input int len);
        int dw;
        dw = (len == 0) ? 1024 : len;
        return (dw + 1) / 2;
    endfunction

    always @(negedge sys_clk) begin
        logic [NB-1:0] eg, ed;
        bit beat;
        cyc++;
        eg = '0;
        ed = '1;
        if (md_moving || md_closing) eg[md_owner] = 1'b1;
        beat = md_moving && !s_src_rdy_n[md_owner] && !m_dst_rdy_n;
        if (chk_on) begin
            chk("m_req_to_send", 64'(m_req_to_send), 64'(md_asking));
            chk("s_grant", 64'(s_grant), 64'(eg));
            if (md_moving) begin
                ed[md_owner] = m_dst_rdy_n;
                chk("m_src_rdy_n", 64'(m_src_rdy_n), 64'(s_src_rdy_n[md_owner]));
            end else begin
                chk("m_src_rdy_n", 64'(m_src_rdy_n), 64'd1);
            end
            chk("s_dst_rdy_n", 64'(s_dst_rdy_n), 64'(ed));
            chk("m_data", m_data, s_data[md_mux*64 +: 64]);
            chk("m_address", m_address, s_address[md_mux*64 +: 64]);
            chk("hdr_a", 64'({m_fmt_type, m_length_in_dw, m_ldwbe_fdwbe, m_attr, m_lower_address}),
                64'({s_fmt_type[md_mux*7 +: 7], s_length_in_dw[md_mux*10 +: 10],
                     s_ldwbe_fdwbe[md_mux*8 +: 8], s_attr[md_mux*2 +: 2], s_lower_address[md_mux*7 +: 7]}));
            chk("hdr_b", 64'({m_transaction_id, m_byte_count}),
                64'({s_transaction_id[md_mux*24 +: 24], s_byte_count[md_mux*13 +: 13]}));
        end
        if (sys_reset) begin
            md_asking = 1'b0; md_moving = 1'b0; md_closing = 1'b0;
            md_owner = 0; md_mux = 0; md_last = NB - 1;
        end else begin
            if ((md_moving || md_closing) && s_grant[md_owner]) md_gcyc++;
            if (md_closing) begin
                md_closing = 1'b0;
                md_last = md_owner;
                log_q.push_back('{md_owner, md_beats, md_gcyc, md_first, md_lastb});
            end else if (md_moving) begin
                if (beat) begin
                    md_beats++;
                    if (md_first < 0) md_first = cyc;
                    md_lastb = cyc;
                    md_left--;
                    if (md_left == 0) begin
                        md_moving = 1'b0;
                        md_closing = 1'b1;
                    end
                end
            end else if (md_asking) begin
                if (m_grant) begin
                    md_asking = 1'b0; md_moving = 1'b1;
                    md_left = beats_of(int'(s_length_in_dw[md_owner*10 +: 10]));
                    md_beats = 0; md_gcyc = 0; md_first = -1;
                end
            end else if (cfg_bus_mast_en && s_req_to_send != '0) begin
                md_owner = rr_pick(md_last, s_req_to_send);
                md_mux = md_owner;
                md_asking = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        for (int a = 0; a < NB; a++) begin
            if (!keep_req[a] && s_grant[a]) s_req_to_send[a] = 1'b0;
            s_data[a*64 +: 64]          = {$urandom, $urandom};
            s_address[a*64 +: 64]       = {$urandom, $urandom};
            s_fmt_type[a*7 +: 7]        = 7'($urandom);
            s_ldwbe_fdwbe[a*8 +: 8]     = 8'($urandom);
            s_attr[a*2 +: 2]            = 2'($urandom);
            s_transaction_id[a*24 +: 24] = 24'($urandom);
            s_byte_count[a*13 +: 13]    = 13'($urandom);
            s_lower_address[a*7 +: 7]   = 7'($urandom);
            s_length_in_dw[a*10 +: 10]  = 10'(len_cfg[a]);
        end
    endtask

    task automatic wait_tlps(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("tlp_timeout", 64'(log_q.size() >= n), 64'd1);
    endtask

    task automatic request(input int a, input int len);
        len_cfg[a] = len;
        s_length_in_dw[a*10 +: 10] = 10'(len);
        s_req_to_send[a] = 1'b1;
    endtask

    task automatic check_reset_outputs();
        #1;
        chk("rst_s_grant", 64'(s_grant), 64'd0);
        chk("rst_m_req", 64'(m_req_to_send), 64'd0);
        chk("rst_m_src_rdy_n", 64'(m_src_rdy_n), 64'd1);
        chk("rst_s_dst_rdy_n", 64'(s_dst_rdy_n), 64'(3'b111));
        chk("rst_mux_addr", m_address, s_address[63:0]);
        chk("rst_mux_data", m_data, s_data[63:0]);
    endtask

    typedef struct { int agent; int len; int beats; int gcyc; } vec_t;
    vec_t tbl [8];
    tlp_t t;

    initial begin
        tbl[0] = '{0, 1, 1, 2};      tbl[1] = '{1, 2, 1, 2};
        tbl[2] = '{2, 3, 2, 3};      tbl[3] = '{0, 4, 2, 3};
        tbl[4] = '{1, 5, 3, 4};      tbl[5] = '{2, 1023, 512, 513};
        tbl[6] = '{1, 0, 512, 513};  tbl[7] = '{0, 1022, 511, 512};
        for (int a = 0; a < NB; a++) begin len_cfg[a] = 1; keep_req[a] = 1'b0; end
        sys_reset = 1'b1; cfg_bus_mast_en = 1'b1; s_req_to_send = '0;
        s_src_rdy_n = '1; m_grant = 1'b0; m_dst_rdy_n = 1'b0;
        s_data = '0; s_address = '0; s_fmt_type = '0; s_length_in_dw = '0;
        s_ldwbe_fdwbe = '0; s_attr = '0; s_transaction_id = '0; s_byte_count = '0;
        s_lower_address = '0;
        repeat (3) tick();
        sys_reset = 1'b0;
        chk_on = 1'b1;
        check_reset_outputs();

        // Agent 0, 4 DW, downstream grant arrives two cycles into the request.
        s_src_rdy_n = '0;
        request(0, 4);
        tick(); tick(); tick();
        m_grant = 1'b1;
        wait_tlps(1, 50);
        t = log_q.pop_front();
        chk("t1_owner", 64'(t.owner), 64'd0);
        chk("t1_beats", 64'(t.beats), 64'd2);
        chk("t1_grant_cycles", 64'(t.gcyc), 64'd3);

        // Fresh reset, then agents 0 and 1 request back to back.
        tick(); sys_reset = 1'b1; tick(); sys_reset = 1'b0;
        keep_req[0] = 1'b1; keep_req[1] = 1'b1;
        request(0, 2); request(1, 2);
        log_q.delete();
        wait_tlps(4, 80);
        keep_req[0] = 1'b0; keep_req[1] = 1'b0; s_req_to_send = '0;
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("rot_owner", 64'(log_q[i].owner), 64'(i % 2));
            chk("rot_grant_cycles", 64'(log_q[i].gcyc), 64'd2);
            if (i > 0) chk("rot_gap", 64'(log_q[i].first - log_q[i-1].lastb), 64'd4);
        end
        repeat (4) tick();

        // Length table: one TLP each, always ready, immediate downstream grant.
        foreach (tbl[v]) begin
            log_q.delete();
            request(tbl[v].agent, tbl[v].len);
            wait_tlps(1, 1200);
            if (log_q.size() > 0) begin
                t = log_q.pop_front();
                chk("tbl_owner", 64'(t.owner), 64'(tbl[v].agent));
                chk("tbl_beats", 64'(t.beats), 64'(tbl[v].beats));
                chk("tbl_grant_cycles", 64'(t.gcyc), 64'(tbl[v].gcyc));
            end
            tick();
        end

        // Agent 2, 8 DW, stalls on both sides; other agents assert valid too.
        log_q.delete();
        request(2, 8);
        for (int k = 0; k < 100 && log_q.size() == 0; k++) begin
            tick();
            m_dst_rdy_n = cyc[0];
            s_src_rdy_n = {1'($urandom_range(0, 1)), 2'b00};
        end
        chk("stall_done", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("stall_beats", 64'(log_q[0].beats), 64'd4);
        s_src_rdy_n = '0; m_dst_rdy_n = 1'b0;
        tick();

        // Reset during beat 2 of 4, then agent 1 alone is served first.
        request(0, 8);
        for (int k = 0; k < 40 && !(md_moving && md_beats == 1); k++) tick();
        chk("mid_reset_reached", 64'(md_moving && md_beats == 1), 64'd1);
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        check_reset_outputs();
        log_q.delete();
        request(1, 2);
        wait_tlps(1, 20);
        if (log_q.size() > 0) chk("post_reset_owner", 64'(log_q[0].owner), 64'd1);
        tick();

        // Bus mastering disabled blocks arbitration until released.
        cfg_bus_mast_en = 1'b0;
        request(2, 2);
        repeat (5) begin
            tick();
            #1 chk("mast_off_req", 64'(m_req_to_send), 64'd0);
        end
        cfg_bus_mast_en = 1'b1;
        #1 chk("mast_release_same", 64'(m_req_to_send), 64'd0);
        tick();
        #1 chk("mast_release_next", 64'(m_req_to_send), 64'd1);
        log_q.delete();
        wait_tlps(1, 20);

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            tick();
            for (int a = 0; a < NB; a++) begin
                if (!s_req_to_send[a] && !s_grant[a] && $urandom_range(0, 5) == 0)
                    request(a, int'($urandom_range(1, 12)));
                else if (s_req_to_send[a] && !s_grant[a] && $urandom_range(0, 49) == 0)
                    s_req_to_send[a] = 1'b0;
            end
            m_grant = ($urandom_range(0, 2) != 0);
            cfg_bus_mast_en = ($urandom_range(0, 9) != 0);
            s_src_rdy_n = NB'($urandom);
            m_dst_rdy_n = 1'($urandom);
        end
        cfg_bus_mast_en = 1'b1; m_grant = 1'b1; s_src_rdy_n = '0; m_dst_rdy_n = 1'b0;
        s_req_to_send = '0;
        for (int k = 0; k < 200 && (md_asking || md_moving || md_closing); k++) tick();
        chk("drain", 64'(md_asking || md_moving || md_closing), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
